// File: rtl/cfi_shadow_stack_pkg.sv
// Shared types and helpers for the commit-stage CFI blocks (shadow stack and landing-pad monitor).
// Carries the subset of the scoreboard entry that control-flow checking needs.
package cfi_shadow_stack_pkg;

    localparam int unsigned VLEN            = 64;
    localparam int unsigned NR_COMMIT_PORTS = 2;

    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;
    typedef enum logic [6:0] {ADD, SUB, XORL, JALR, EQ, NE} fu_op;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        fu_t             fu;
        fu_op            op;
        logic [4:0]      rs1;
        logic [4:0]      rd;
        logic            is_compressed;
    } scoreboard_entry_t;

    typedef enum logic {IDLE, WAIT_TGT} cfi_state_e;

    // JAL is committed as CTRL_FLOW/ADD, so both encodings link through ra.
    function automatic logic is_call(input scoreboard_entry_t instr);
        return (instr.fu == CTRL_FLOW) && (instr.rd == REG_RA) &&
               ((instr.op == JALR) || (instr.op == ADD));
    endfunction

    function automatic logic is_ret(input scoreboard_entry_t instr);
        return (instr.fu == CTRL_FLOW) && (instr.op == JALR) &&
               (instr.rs1 == REG_RA) && (instr.rd == REG_ZERO);
    endfunction

    function automatic logic [VLEN-1:0] ret_addr(input scoreboard_entry_t instr);
        return instr.pc + (instr.is_compressed ? VLEN'(2) : VLEN'(4));
    endfunction

endpackage

// File: rtl/cfi_shadow_stack_if.sv
// Commit-port observation bundle and result flags of the shadow stack.
interface cfi_shadow_stack_if
    import cfi_shadow_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8
);
    scoreboard_entry_t            commit_instr_i [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0]   commit_ack_i;
    logic                         clear_i;
    logic                         violation_o;
    logic [CNT_W-1:0]             violation_cnt_o;
    logic                         overflow_o;
    logic                         underflow_o;
    logic [$clog2(DEPTH):0]       depth_o;
    logic [VLEN-1:0]              expected_pc_o;

    modport master (
        output commit_instr_i, commit_ack_i, clear_i,
        input  violation_o, violation_cnt_o, overflow_o, underflow_o, depth_o, expected_pc_o
    );

    modport slave (
        input  commit_instr_i, commit_ack_i, clear_i,
        output violation_o, violation_cnt_o, overflow_o, underflow_o, depth_o, expected_pc_o
    );
endinterface

// File: rtl/cfi_shadow_stack_ras_lifo.sv
// Circular return-address LIFO; port 0's push/pop is applied before port 1's in the same cycle.
module cfi_ras_lifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push0_i,
    input  logic                     pop0_i,
    input  logic [WIDTH-1:0]         push0Data_i,
    input  logic                     push1_i,
    input  logic                     pop1_i,
    input  logic [WIDTH-1:0]         push1Data_i,
    output logic [WIDTH-1:0]         top_o,
    output logic [WIDTH-1:0]         nextTop_o,
    output logic [$clog2(DEPTH):0]   depth_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptrMid, ptr_d;
    logic [PTR_W:0]   cnt_q, cntMid, cnt_d;

    // A push when full keeps the count at DEPTH; ptr then lands on the oldest slot and overwrites it.
    always_comb begin
        ptrMid = ptr_q;
        cntMid = cnt_q;
        if (push0_i) begin
            ptrMid = ptr_q + PTR_W'(1);
            cntMid = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + (PTR_W+1)'(1);
        end else if (pop0_i) begin
            ptrMid = ptr_q - PTR_W'(1);
            cntMid = cnt_q - (PTR_W+1)'(1);
        end
        ptr_d = ptrMid;
        cnt_d = cntMid;
        if (push1_i) begin
            ptr_d = ptrMid + PTR_W'(1);
            cnt_d = (cntMid == FULL_CNT) ? cntMid : cntMid + (PTR_W+1)'(1);
        end else if (pop1_i) begin
            ptr_d = ptrMid - PTR_W'(1);
            cnt_d = cntMid - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clear_i) begin
            if (push0_i) mem_q[ptr_q]  <= push0Data_i;
            if (push1_i) mem_q[ptrMid] <= push1Data_i;
        end
    end

    assign top_o     = mem_q[ptr_q - PTR_W'(1)];
    assign nextTop_o = mem_q[ptr_q - PTR_W'(2)];
    assign depth_o   = cnt_q;
    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/cfi_shadow_stack.sv
// Passive commit-stage shadow stack: records call return addresses and checks the commit following each return.
module cfi_shadow_stack
    import cfi_shadow_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cfi_shadow_stack_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;
    localparam logic [DEPTH_W-1:0] FULL_CNT = DEPTH_W'(DEPTH);

    cfi_state_e       state_q;
    logic [VLEN-1:0]  expectedPc_q, expectedPc_d;
    logic             violation_q, violation_d;
    logic [CNT_W-1:0] violationCnt_q;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             pending_d;

    logic [VLEN-1:0]    lifoTop, lifoNext;
    logic [DEPTH_W-1:0] lifoDepth;
    logic               lifoFull, lifoEmpty;
    logic [1:0]         push, pop;
    logic [VLEN-1:0]    pushData [2];

    logic [VLEN-1:0]    curTop, curNext;
    logic [DEPTH_W-1:0] curDepth;
    logic               curFull, curEmpty;

    // Walk the ports in order, tracking the stack view each port sees after the earlier port's effect.
    always_comb begin
        pending_d    = (state_q == WAIT_TGT);
        expectedPc_d = expectedPc_q;
        violation_d  = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        push         = '0;
        pop          = '0;
        pushData[0]  = '0;
        pushData[1]  = '0;
        curTop       = lifoTop;
        curNext      = lifoNext;
        curDepth     = lifoDepth;
        curFull      = lifoFull;
        curEmpty     = lifoEmpty;
        for (int p = 0; p < 2; p++) begin
            if (bus.commit_ack_i[p]) begin
                if (pending_d) begin
                    if (bus.commit_instr_i[p].pc != expectedPc_d) violation_d = 1'b1;
                    pending_d = 1'b0;
                end
                if (is_call(bus.commit_instr_i[p])) begin
                    push[p]     = 1'b1;
                    pushData[p] = ret_addr(bus.commit_instr_i[p]);
                    if (curFull) overflow_d = 1'b1;
                    else         curDepth   = curDepth + DEPTH_W'(1);
                    curNext = curTop;
                    curTop  = pushData[p];
                end else if (is_ret(bus.commit_instr_i[p])) begin
                    if (curEmpty) begin
                        underflow_d = 1'b1;
                    end else begin
                        pop[p]       = 1'b1;
                        expectedPc_d = curTop;
                        pending_d    = 1'b1;
                        curDepth     = curDepth - DEPTH_W'(1);
                        curTop       = curNext;
                    end
                end
                curFull  = (curDepth == FULL_CNT);
                curEmpty = (curDepth == '0);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            expectedPc_q   <= '0;
            violation_q    <= 1'b0;
            violationCnt_q <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else if (bus.clear_i) begin
            state_q        <= IDLE;
            expectedPc_q   <= '0;
            violation_q    <= 1'b0;
            violationCnt_q <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q      <= pending_d ? WAIT_TGT : IDLE;
            expectedPc_q <= expectedPc_d;
            violation_q  <= violation_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            if (violation_d && (violationCnt_q != '1))
                violationCnt_q <= violationCnt_q + CNT_W'(1);
        end
    end

    cfi_ras_lifo #(
        .DEPTH (DEPTH),
        .WIDTH (VLEN)
    ) uLifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (bus.clear_i),
        .push0_i     (push[0]),
        .pop0_i      (pop[0]),
        .push0Data_i (pushData[0]),
        .push1_i     (push[1]),
        .pop1_i      (pop[1]),
        .push1Data_i (pushData[1]),
        .top_o       (lifoTop),
        .nextTop_o   (lifoNext),
        .depth_o     (lifoDepth),
        .full_o      (lifoFull),
        .empty_o     (lifoEmpty)
    );

    assign bus.violation_o     = violation_q;
    assign bus.violation_cnt_o = violationCnt_q;
    assign bus.overflow_o      = overflow_q;
    assign bus.underflow_o     = underflow_q;
    assign bus.depth_o         = lifoDepth;
    assign bus.expected_pc_o   = expectedPc_q;

endmodule

// File: tb/tb_cfi_shadow_stack.sv
// Scoreboard bench for cfi_shadow_stack: a queue-based software stack predicts every registered output.
module tb_cfi_shadow_stack;
    import cfi_shadow_stack_pkg::*;

    typedef struct {
        logic        viol;
        logic [7:0]  cnt;
        logic        ovf;
        logic        unf;
        logic [4:0]  depth;
        logic [63:0] pc;
        string       tag;
    } expect_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    cfi_shadow_stack_if bus ();

    cfi_shadow_stack dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int vectorsApplied = 0;
    int miscompares    = 0;

    expect_t     expQ[$];
    logic [63:0] mStack[$];
    logic        mPend;
    logic [63:0] mExp;
    logic [7:0]  mCnt;
    logic        mOvf, mUnf;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic scoreboard_entry_t mkCall(input logic [63:0] pc, input logic rvc, input logic viaJalr);
        scoreboard_entry_t e;
        e.pc = pc; e.fu = CTRL_FLOW; e.op = viaJalr ? JALR : ADD;
        e.rs1 = viaJalr ? 5'd1 : 5'd0; e.rd = 5'd1; e.is_compressed = rvc;
        return e;
    endfunction

    function automatic scoreboard_entry_t mkRet(input logic [63:0] pc);
        scoreboard_entry_t e;
        e.pc = pc; e.fu = CTRL_FLOW; e.op = JALR; e.rs1 = 5'd1; e.rd = 5'd0; e.is_compressed = 1'b0;
        return e;
    endfunction

    function automatic scoreboard_entry_t mkOther(input logic [63:0] pc);
        scoreboard_entry_t e;
        e.pc = pc; e.fu = ALU; e.op = ADD; e.rs1 = 5'd3; e.rd = 5'd1; e.is_compressed = 1'b0;
        return e;
    endfunction

    task automatic resetModel();
        mStack.delete();
        mPend = 1'b0; mExp = '0; mCnt = '0; mOvf = 1'b0; mUnf = 1'b0;
    endtask

    // Reference behaviour: ordered per-port check, then call/return classification.
    task automatic modelStep(input scoreboard_entry_t ins[2], input logic [1:0] ack, input logic clr, output logic mis);
        mis = 1'b0;
        if (clr) begin
            resetModel();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
                logic call, ret;
                if (mPend) begin
                    if (ins[p].pc != mExp) mis = 1'b1;
                    mPend = 1'b0;
                end
                call = ins[p].fu == CTRL_FLOW && ins[p].rd == 5'd1 && (ins[p].op == JALR || ins[p].op == ADD);
                ret  = !call && ins[p].fu == CTRL_FLOW && ins[p].op == JALR && ins[p].rs1 == 5'd1 && ins[p].rd == 5'd0;
                if (call) begin
                    if (mStack.size() == 16) begin
                        void'(mStack.pop_front());
                        mOvf = 1'b1;
                    end
                    mStack.push_back(ins[p].pc + (ins[p].is_compressed ? 64'd2 : 64'd4));
                end else if (ret) begin
                    if (mStack.size() == 0) mUnf = 1'b1;
                    else begin
                        mExp  = mStack.pop_back();
                        mPend = 1'b1;
                    end
                end
            end
        end
        if (mis && mCnt != 8'hFF) mCnt = mCnt + 8'd1;
    endtask

    task automatic applyStimulus(input string tag, input scoreboard_entry_t i0, input scoreboard_entry_t i1,
                                 input logic [1:0] ack, input logic clr);
        scoreboard_entry_t ins[2];
        expect_t e;
        logic mis;
        @(negedge clk_i);
        ins[0] = i0; ins[1] = i1;
        bus.commit_instr_i[0] = i0;
        bus.commit_instr_i[1] = i1;
        bus.commit_ack_i      = ack;
        bus.clear_i           = clr;
        modelStep(ins, ack, clr, mis);
        e.viol = mis; e.cnt = mCnt; e.ovf = mOvf; e.unf = mUnf;
        e.depth = 5'(mStack.size()); e.pc = mExp; e.tag = tag;
        expQ.push_back(e);
        @(posedge clk_i);
        #1;
        bus.commit_ack_i = '0;
        bus.clear_i      = 1'b0;
        if (expQ.size() == 0) begin
            checkOutput({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".violation"},   64'(bus.violation_o),     64'(e.viol));
            checkOutput({e.tag, ".cnt"},         64'(bus.violation_cnt_o), 64'(e.cnt));
            checkOutput({e.tag, ".overflow"},    64'(bus.overflow_o),      64'(e.ovf));
            checkOutput({e.tag, ".underflow"},   64'(bus.underflow_o),     64'(e.unf));
            checkOutput({e.tag, ".depth"},       64'(bus.depth_o),         64'(e.depth));
            checkOutput({e.tag, ".expected_pc"}, bus.expected_pc_o,        e.pc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".violation"},   64'(bus.violation_o),     64'd0);
        checkOutput({tag, ".cnt"},         64'(bus.violation_cnt_o), 64'd0);
        checkOutput({tag, ".overflow"},    64'(bus.overflow_o),      64'd0);
        checkOutput({tag, ".underflow"},   64'(bus.underflow_o),     64'd0);
        checkOutput({tag, ".depth"},       64'(bus.depth_o),         64'd0);
        checkOutput({tag, ".expected_pc"}, bus.expected_pc_o,        64'd0);
    endtask

    scoreboard_entry_t nop;

    initial begin
        nop = mkOther(64'd0);
        bus.commit_instr_i[0] = nop;
        bus.commit_instr_i[1] = nop;
        bus.commit_ack_i = '0;
        bus.clear_i      = 1'b0;
        resetModel();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1 checkAllZero("reset");

        // Matching return target
        applyStimulus("m.call", mkCall(64'h8000_0100, 1'b0, 1'b0), nop, 2'b01, 1'b0);
        applyStimulus("m.idle", nop, nop, 2'b00, 1'b0);
        applyStimulus("m.ret",  mkRet(64'h8000_0300), nop, 2'b01, 1'b0);
        applyStimulus("m.hold", nop, nop, 2'b00, 1'b0);
        applyStimulus("m.tgt",  mkOther(64'h8000_0104), nop, 2'b01, 1'b0);
        applyStimulus("m.post", nop, nop, 2'b00, 1'b0);

        // Mismatching return target
        applyStimulus("x.call", mkCall(64'h8000_0100, 1'b0, 1'b1), nop, 2'b01, 1'b0);
        applyStimulus("x.ret",  mkRet(64'h8000_0300), nop, 2'b01, 1'b0);
        applyStimulus("x.tgt",  mkOther(64'h8000_0200), nop, 2'b01, 1'b0);
        applyStimulus("x.post", mkOther(64'h8000_0204), nop, 2'b01, 1'b0);

        // Compressed call plus return in one cycle
        applyStimulus("c.pair", mkCall(64'h8000_0010, 1'b1, 1'b0), mkRet(64'h8000_0800), 2'b11, 1'b0);
        applyStimulus("c.tgt",  mkOther(64'h8000_0012), nop, 2'b01, 1'b0);

        // Double call, double return, then target
        applyStimulus("d.calls", mkCall(64'h8000_0400, 1'b0, 1'b0), mkCall(64'h8000_0500, 1'b1, 1'b1), 2'b11, 1'b0);
        applyStimulus("d.rets",  mkRet(64'h8000_0502), mkRet(64'h8000_0502), 2'b11, 1'b0);
        applyStimulus("d.tgt",   nop, mkOther(64'h8000_0404), 2'b10, 1'b0);

        // Overflow by 17 nested calls, 16 matching returns, then underflow
        for (int i = 0; i < 17; i++)
            applyStimulus($sformatf("o.call%0d", i), mkCall(64'h8000_1000 + 64'(i) * 64'h10, 1'b0, 1'b0), nop, 2'b01, 1'b0);
        for (int k = 16; k >= 1; k--)
            applyStimulus($sformatf("o.ret%0d", k), mkRet(64'h9000_0000),
                          mkOther(64'h8000_1000 + 64'(k) * 64'h10 + 64'd4), 2'b11, 1'b0);
        applyStimulus("o.ret17", mkRet(64'h9000_0000), nop, 2'b01, 1'b0);
        applyStimulus("o.after", mkOther(64'h1234), nop, 2'b01, 1'b0);

        // Empty return, then clear while a target is pending
        applyStimulus("e.clr",  nop, nop, 2'b00, 1'b1);
        applyStimulus("e.ret",  mkRet(64'h9000_0000), nop, 2'b01, 1'b0);
        applyStimulus("e.call", mkCall(64'h8000_2000, 1'b0, 1'b0), nop, 2'b01, 1'b0);
        applyStimulus("e.ret2", mkRet(64'h9000_0000), nop, 2'b01, 1'b0);
        applyStimulus("e.clr2", mkCall(64'h8000_3000, 1'b0, 1'b0), nop, 2'b01, 1'b1);
        checkAllZero("e.cleared");
        applyStimulus("e.next", mkOther(64'hDEAD_0000), nop, 2'b01, 1'b0);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            applyStimulus("s.pair", mkCall(64'h8000_4000, 1'b0, 1'b0), mkRet(64'h8000_5000), 2'b11, 1'b0);
            applyStimulus("s.bad",  mkOther(64'h8000_6000 + 64'(i)), nop, 2'b01, 1'b0);
        end
        checkOutput("s.saturated", 64'(bus.violation_cnt_o), 64'd255);

        // Async reset in the middle of the burst
        for (int j = 0; j < 4; j++) begin
            applyStimulus("r.pair", mkCall(64'h8000_4000, 1'b0, 1'b0), mkRet(64'h8000_5000), 2'b11, 1'b0);
            applyStimulus("r.bad",  mkOther(64'h8000_7000), nop, 2'b01, 1'b0);
        end
        applyStimulus("r.pair2", mkCall(64'h8000_4000, 1'b0, 1'b0), mkRet(64'h8000_5000), 2'b11, 1'b0);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1 checkAllZero("r.async");
        resetModel();
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus("r.after", mkOther(64'h8000_7000), nop, 2'b01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
